// File: rtl/lenet5_drv_pkg.sv
// -----------------------------------------------------------------------------
// lenet5_drv_pkg
// Shared definitions for the LeNet-5 stream driver.
//   - FSM state encoding (legacy-compatible localparam constants)
//   - read-pipeline phase tags
//   - default load sizes, matching the accelerator's internal buffer depths
//   - counter widths
// -----------------------------------------------------------------------------
package lenet5_drv_pkg;

   // Load sizes: conv1..fc weights, fc biases, 32x32x1 input image.
   localparam int unsigned N_WEIGHT_DEF = 3220;
   localparam int unsigned N_BIAS_DEF   = 10;
   localparam int unsigned N_PIX_DEF    = 1024;

   localparam int unsigned WCNT_W = 12;
   localparam int unsigned TCNT_W = 16;

   // Driver FSM states.
   typedef logic [2:0] drv_state_t;
   localparam drv_state_t StIdle    = 3'd0;
   localparam drv_state_t StLdW     = 3'd1;
   localparam drv_state_t StLdB     = 3'd2;
   localparam drv_state_t StLdF     = 3'd3;
   localparam drv_state_t StWaitRes = 3'd4;
   localparam drv_state_t StPend    = 3'd5;
   localparam drv_state_t StDone    = 3'd6;

   // Tag carried alongside each read so its data lands in the right register.
   typedef enum logic [1:0] {
      PhNone   = 2'd0,
      PhWeight = 2'd1,
      PhBias   = 2'd2,
      PhFmap   = 2'd3
   } phase_e;

   // Weight and bias words share the early (v1) ce timing.
   function automatic logic is_wb_phase(input phase_e ph);
      return (ph == PhWeight) || (ph == PhBias);
   endfunction

endpackage

// File: rtl/lenet5_drv_rdpipe.sv
// -----------------------------------------------------------------------------
// lenet5_drv_rdpipe
// Two-stage valid/tag pipeline behind the memory read strobe.
//   v1: memory data is on i_mem_data (one cycle after the strobe)
//   v2: data has been captured into the register selected by the phase tag
// Ports:
//   clk, global_rst_n  clock, async active-low reset
//   i_rd, i_phase      read strobe and phase tag issued this cycle (v0)
//   i_mem_data         memory read data, valid at v1
//   o_ce               accelerator ce: v1 for weight/bias, v2 for fmap
//   o_weight/o_bias/o_fmap  phase-routed data registers (hold when not tagged)
//   o_empty            no read in flight in either stage
// -----------------------------------------------------------------------------
module lenet5_drv_rdpipe
   import lenet5_drv_pkg::*;
#(
   parameter int unsigned W_BW   = 8,
   parameter int unsigned B_BW   = 16,
   parameter int unsigned I_BW   = 8,
   parameter int unsigned MEM_BW = 16
) (
   input  logic              clk,
   input  logic              global_rst_n,
   input  logic              i_rd,
   input  phase_e            i_phase,
   input  logic [MEM_BW-1:0] i_mem_data,
   output logic              o_ce,
   output logic [W_BW-1:0]   o_weight,
   output logic [B_BW-1:0]   o_bias,
   output logic [I_BW-1:0]   o_fmap,
   output logic              o_empty
);

   logic            v1_q, v2_q;
   phase_e          tag1_q, tag2_q;
   logic [W_BW-1:0] weight_q;
   logic [B_BW-1:0] bias_q;
   logic [I_BW-1:0] fmap_q;
   logic            ld_weight, ld_bias, ld_fmap;
   logic            mem_data_unused;

   // Only the low bits of the memory word are consumed.
   assign mem_data_unused = ^i_mem_data;

   assign ld_weight = v1_q && (tag1_q == PhWeight);
   assign ld_bias   = v1_q && (tag1_q == PhBias);
   assign ld_fmap   = v1_q && (tag1_q == PhFmap);

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         tag1_q <= PhNone;
         tag2_q <= PhNone;
      end else begin
         v1_q   <= i_rd;
         v2_q   <= v1_q;
         tag1_q <= i_rd ? i_phase : PhNone;
         tag2_q <= tag1_q;
      end
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         weight_q <= '0;
         bias_q   <= '0;
         fmap_q   <= '0;
      end else begin
         if (ld_weight) weight_q <= i_mem_data[W_BW-1:0];
         if (ld_bias)   bias_q   <= i_mem_data[B_BW-1:0];
         if (ld_fmap)   fmap_q   <= i_mem_data[I_BW-1:0];
      end
   end

   // The accelerator registers ce and the weight/bias word itself, so ce leads
   // the driver's data register by one cycle; fmap is consumed combinationally.
   always_comb begin
      o_ce = (v1_q && is_wb_phase(tag1_q)) || (v2_q && (tag2_q == PhFmap));
   end

   assign o_weight = weight_q;
   assign o_bias   = bias_q;
   assign o_fmap   = fmap_q;
   assign o_empty  = !v1_q && !v2_q;

endmodule

// File: rtl/lenet5_stream_driver.sv
// -----------------------------------------------------------------------------
// lenet5_stream_driver
// Transmit-side sequencer for the LeNet-5 accelerator. For each image it
// streams all weights, the FC biases and the image pixels from a unified word
// memory into the accelerator's serial inputs, waits for the classification,
// captures the result and pulses the accelerator's process-end reset.
// Ports:
//   clk, global_rst_n        clock, async active-low reset
//   i_start, i_num_img       batch start pulse and image count (sampled on start)
//   o_mem_rd, o_mem_addr     memory read strobe/address, data back on i_mem_data
//   o_ce, o_weight, o_bias_fc, o_fmap, o_rst_processEnd   accelerator drive
//   i_cls_result, i_cls_en, i_cls_end                      accelerator result
//   o_res_valid, o_res_class, o_res_idx                    captured result
//   o_busy, o_done, o_timeout                              status
// -----------------------------------------------------------------------------
module lenet5_stream_driver
   import lenet5_drv_pkg::*;
#(
   parameter int unsigned W_BW        = 8,
   parameter int unsigned B_BW        = 16,
   parameter int unsigned I_BW        = 8,
   parameter int unsigned MEM_BW      = 16,
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned N_WEIGHT    = N_WEIGHT_DEF,
   parameter int unsigned N_BIAS      = N_BIAS_DEF,
   parameter int unsigned N_PIX       = N_PIX_DEF,
   parameter int unsigned W_BASE      = 0,
   parameter int unsigned B_BASE      = 3220,
   parameter int unsigned F_BASE      = 3230,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic              clk,
   input  logic              global_rst_n,
   input  logic              i_start,
   input  logic [7:0]        i_num_img,
   output logic              o_mem_rd,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [MEM_BW-1:0] i_mem_data,
   output logic              o_ce,
   output logic              o_rst_processEnd,
   output logic [W_BW-1:0]   o_weight,
   output logic [B_BW-1:0]   o_bias_fc,
   output logic [I_BW-1:0]   o_fmap,
   input  logic [3:0]        i_cls_result,
   input  logic              i_cls_en,
   input  logic              i_cls_end,
   output logic              o_res_valid,
   output logic [3:0]        o_res_class,
   output logic [7:0]        o_res_idx,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_timeout
);

   localparam logic [WCNT_W-1:0] LastW   = WCNT_W'(N_WEIGHT - 1);
   localparam logic [WCNT_W-1:0] LastB   = WCNT_W'(N_BIAS - 1);
   localparam logic [WCNT_W-1:0] LastF   = WCNT_W'(N_PIX - 1);
   localparam logic [TCNT_W-1:0] LastTmo = TCNT_W'(TIMEOUT_CYC - 1);

   drv_state_t        state_q, state_d;
   logic [WCNT_W-1:0] cnt_q, cnt_d;
   logic [TCNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]        num_img_q, num_img_d;
   logic [7:0]        img_idx_q, img_idx_d;
   logic [ADDR_W-1:0] img_off_q, img_off_d;     // img_idx * N_PIX, kept as a running sum
   logic              end_seen_q, end_seen_d;
   logic              timeout_q, timeout_d;
   logic              done_q, done_d;
   logic              res_valid_q, res_valid_d;
   logic [3:0]        res_class_q, res_class_d;
   logic [7:0]        res_idx_q, res_idx_d;

   logic              rd;
   phase_e            rd_phase;
   logic [ADDR_W-1:0] rd_addr;
   logic              pipe_empty;

   // ---------------------------------------------------------------------------
   // Sequencer next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      num_img_d  = num_img_q;
      img_idx_d  = img_idx_q;
      img_off_d  = img_off_q;
      end_seen_d = end_seen_q;
      timeout_d  = timeout_q;
      rd         = 1'b0;
      rd_phase   = PhNone;
      rd_addr    = '0;

      unique case (state_q)
         StIdle: begin
            if (i_start) begin
               num_img_d  = i_num_img;
               timeout_d  = 1'b0;
               img_idx_d  = '0;
               img_off_d  = '0;
               cnt_d      = '0;
               tmo_cnt_d  = '0;
               end_seen_d = 1'b0;
               state_d    = (i_num_img == 8'd0) ? StDone : StLdW;
            end
         end

         StLdW: begin
            rd       = 1'b1;
            rd_phase = PhWeight;
            rd_addr  = ADDR_W'(W_BASE) + ADDR_W'(cnt_q);
            if (cnt_q == LastW) begin
               cnt_d   = '0;
               state_d = StLdB;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StLdB: begin
            rd       = 1'b1;
            rd_phase = PhBias;
            rd_addr  = ADDR_W'(B_BASE) + ADDR_W'(cnt_q);
            if (cnt_q == LastB) begin
               cnt_d   = '0;
               state_d = StLdF;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StLdF: begin
            rd       = 1'b1;
            rd_phase = PhFmap;
            rd_addr  = ADDR_W'(F_BASE) + img_off_q + ADDR_W'(cnt_q);
            if (cnt_q == LastF) begin
               cnt_d   = '0;
               state_d = StWaitRes;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StWaitRes: begin
            // An early cls_end is remembered so PEND never overlaps a draining ce.
            if (i_cls_end) end_seen_d = 1'b1;
            if (pipe_empty) begin
               if (i_cls_end || end_seen_q) begin
                  end_seen_d = 1'b0;
                  tmo_cnt_d  = '0;
                  state_d    = StPend;
               end else if (tmo_cnt_q == LastTmo) begin
                  timeout_d = 1'b1;
                  tmo_cnt_d = '0;
                  state_d   = StDone;
               end else if (tmo_cnt_q != '1) begin
                  tmo_cnt_d = tmo_cnt_q + 1'b1;
               end
            end
         end

         StPend: begin
            img_idx_d = img_idx_q + 8'd1;
            img_off_d = img_off_q + ADDR_W'(N_PIX);
            // Process-end clears the accelerator buffers, so weights reload too.
            state_d   = ((img_idx_q + 8'd1) == num_img_q) ? StDone : StLdW;
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Result capture and status pulses
   // ---------------------------------------------------------------------------
   always_comb begin
      res_valid_d = 1'b0;
      res_class_d = res_class_q;
      res_idx_d   = res_idx_q;
      if ((state_q == StWaitRes) && i_cls_en) begin
         res_valid_d = 1'b1;
         res_class_d = i_cls_result;
         res_idx_d   = img_idx_q;
      end
      done_d = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         tmo_cnt_q   <= '0;
         num_img_q   <= '0;
         img_idx_q   <= '0;
         img_off_q   <= '0;
         end_seen_q  <= 1'b0;
         timeout_q   <= 1'b0;
         done_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_class_q <= '0;
         res_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         num_img_q   <= num_img_d;
         img_idx_q   <= img_idx_d;
         img_off_q   <= img_off_d;
         end_seen_q  <= end_seen_d;
         timeout_q   <= timeout_d;
         done_q      <= done_d;
         res_valid_q <= res_valid_d;
         res_class_q <= res_class_d;
         res_idx_q   <= res_idx_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Read pipeline
   // ---------------------------------------------------------------------------
   lenet5_drv_rdpipe #(
      .W_BW   (W_BW),
      .B_BW   (B_BW),
      .I_BW   (I_BW),
      .MEM_BW (MEM_BW)
   ) u_rdpipe (
      .clk          (clk),
      .global_rst_n (global_rst_n),
      .i_rd         (rd),
      .i_phase      (rd_phase),
      .i_mem_data   (i_mem_data),
      .o_ce         (o_ce),
      .o_weight     (o_weight),
      .o_bias       (o_bias_fc),
      .o_fmap       (o_fmap),
      .o_empty      (pipe_empty)
   );

   assign o_mem_rd         = rd;
   assign o_mem_addr       = rd_addr;
   // PEND is only reachable with an empty pipeline, so this never overlaps ce.
   assign o_rst_processEnd = (state_q == StPend);
   assign o_busy           = (state_q != StIdle);
   assign o_done           = done_q;
   assign o_timeout        = timeout_q;
   assign o_res_valid      = res_valid_q;
   assign o_res_class      = res_class_q;
   assign o_res_idx        = res_idx_q;

endmodule

// File: tb/tb_lenet5_stream_driver.sv
// -----------------------------------------------------------------------------
// tb_lenet5_stream_driver
// Directed bench for lenet5_stream_driver (TIMEOUT_CYC shortened to 100).
// A negedge monitor predicts the read address sequence, pushes the expected
// word and ce cycle for every read into a scoreboard queue and pops it when ce
// appears; result captures are checked against an expected-result table.
// -----------------------------------------------------------------------------
module tb_lenet5_stream_driver;

   localparam int NW  = 3220;
   localparam int NB  = 10;
   localparam int NP  = 1024;
   localparam int NWB = NW + NB;
   localparam int NRD = NWB + NP;

   logic        clk = 1'b0;
   logic        global_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_num_img = 8'd0;
   logic        o_mem_rd;
   logic [15:0] o_mem_addr;
   logic [15:0] mem_data;
   logic        o_ce;
   logic        o_rst_processEnd;
   logic [7:0]  o_weight;
   logic [15:0] o_bias_fc;
   logic [7:0]  o_fmap;
   logic [3:0]  i_cls_result = 4'd0;
   logic        i_cls_en = 1'b0;
   logic        i_cls_end = 1'b0;
   logic        o_res_valid;
   logic [3:0]  o_res_class;
   logic [7:0]  o_res_idx;
   logic        o_busy;
   logic        o_done;
   logic        o_timeout;

   always #5 clk = ~clk;

   lenet5_stream_driver #(
      .TIMEOUT_CYC (100)
   ) dut (
      .clk              (clk),
      .global_rst_n     (global_rst_n),
      .i_start          (i_start),
      .i_num_img        (i_num_img),
      .o_mem_rd         (o_mem_rd),
      .o_mem_addr       (o_mem_addr),
      .i_mem_data       (mem_data),
      .o_ce             (o_ce),
      .o_rst_processEnd (o_rst_processEnd),
      .o_weight         (o_weight),
      .o_bias_fc        (o_bias_fc),
      .o_fmap           (o_fmap),
      .i_cls_result     (i_cls_result),
      .i_cls_en         (i_cls_en),
      .i_cls_end        (i_cls_end),
      .o_res_valid      (o_res_valid),
      .o_res_class      (o_res_class),
      .o_res_idx        (o_res_idx),
      .o_busy           (o_busy),
      .o_done           (o_done),
      .o_timeout        (o_timeout)
   );

   // Memory model: word at address A reads back as A, one cycle later.
   always_ff @(posedge clk) if (o_mem_rd) mem_data <= o_mem_addr;

   int cyc = 0;
   always_ff @(posedge clk) cyc <= cyc + 1;

   // ---------------------------------------------------------------------------
   // Monitor / scoreboard (sole writer of everything declared here)
   // ---------------------------------------------------------------------------
   typedef struct {
      int kind;   // 0 weight, 1 bias, 2 fmap
      int val;
      int cyc;
   } sb_t;

   sb_t sbq[$];
   sb_t mon_e;
   int  epoch = 0, seen_epoch = 0;
   int  mk = 0, mimg = 0, mexp = 0;
   int  rd_cnt = 0, rd_w = 0, rd_b = 0, rd_f = 0;
   int  ce_cnt = 0, f_ce_cnt = 0, last_f_ce = 0;
   int  addr_err = 0, data_err = 0, lat_err = 0, overlap_err = 0;
   int  pend_cnt = 0, done_cnt = 0, last_done = 0;
   int  tmo_rise = 0;
   bit  tmo_prev = 1'b0;
   bit  pend_wb = 1'b0;
   int  pend_kind = 0, pend_val = 0;
   int  faddr [8];
   int  res_rd = 0, res_err = 0;

   // Expected results, written only by the stimulus block.
   logic [3:0] exp_cls [16];
   logic [7:0] exp_idx [16];
   int         exp_cyc [16];
   int         res_wr = 0;

   always @(negedge clk) begin
      if (!global_rst_n) begin
         sbq.delete();
         pend_wb  = 1'b0;
         mk       = 0;
         mimg     = 0;
         tmo_prev = 1'b0;
      end else begin
         if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            mk   = 0;
            mimg = 0;
         end
         if (pend_wb) begin
            if (pend_kind == 0) begin
               if (o_weight !== 8'(pend_val)) data_err++;
            end else begin
               if (o_bias_fc !== 16'(pend_val)) data_err++;
            end
            pend_wb = 1'b0;
         end
         if (o_ce) begin
            ce_cnt++;
            if (o_rst_processEnd) overlap_err++;
            if (sbq.size() == 0) begin
               data_err++;
            end else begin
               mon_e = sbq.pop_front();
               if (mon_e.cyc != cyc) lat_err++;
               if (mon_e.kind == 2) begin
                  if (o_fmap !== 8'(mon_e.val)) data_err++;
                  f_ce_cnt++;
                  last_f_ce = cyc;
               end else begin
                  pend_wb   = 1'b1;
                  pend_kind = mon_e.kind;
                  pend_val  = mon_e.val;
               end
            end
         end
         if (o_mem_rd) begin
            rd_cnt++;
            if (o_mem_addr < 16'(NW)) rd_w++;
            else if (o_mem_addr < 16'(NWB)) rd_b++;
            else rd_f++;
            mexp = (mk < NWB) ? mk : mk + mimg * NP;
            if (o_mem_addr !== 16'(mexp)) addr_err++;
            if (mk == NWB && mimg < 8) faddr[mimg] = int'(o_mem_addr);
            mon_e.kind = (mk < NW) ? 0 : ((mk < NWB) ? 1 : 2);
            mon_e.val  = mexp;
            mon_e.cyc  = cyc + ((mk < NWB) ? 1 : 2);
            sbq.push_back(mon_e);
            mk++;
            if (mk == NRD) begin
               mk = 0;
               mimg++;
            end
         end
         if (o_rst_processEnd) pend_cnt++;
         if (o_done) begin
            done_cnt++;
            last_done = cyc;
         end
         if (o_timeout && !tmo_prev) tmo_rise = cyc;
         tmo_prev = o_timeout;
         if (o_res_valid) begin
            if (res_rd < res_wr) begin
               if (o_res_class !== exp_cls[res_rd] || o_res_idx !== exp_idx[res_rd] ||
                   cyc != exp_cyc[res_rd]) res_err++;
               res_rd++;
            end else begin
               res_err++;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus and checks
   // ---------------------------------------------------------------------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_batch(input logic [7:0] n, output int st);
      epoch++;
      @(posedge clk); #1;
      i_num_img = n;
      i_start   = 1'b1;
      st        = cyc;
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic wait_fce(input string tag, input int target);
      int n = 0;
      while (f_ce_cnt < target && n < 8000) begin
         @(negedge clk); #1;
         n++;
      end
      check(tag, f_ce_cnt, target);
   endtask

   task automatic wait_done(input string tag, input int target);
      int n = 0;
      while (done_cnt < target && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      check(tag, done_cnt, target);
   endtask

   task automatic finish_img(input logic [3:0] cls, input bit same, input logic [7:0] idx);
      @(posedge clk); #1;
      i_cls_result    = cls;
      i_cls_en        = 1'b1;
      i_cls_end       = same;
      exp_cls[res_wr] = cls;
      exp_idx[res_wr] = idx;
      exp_cyc[res_wr] = cyc + 1;
      res_wr++;
      @(posedge clk); #1;
      i_cls_en  = 1'b0;
      i_cls_end = 1'b0;
      if (!same) begin
         i_cls_end = 1'b1;
         @(posedge clk); #1;
         i_cls_end = 1'b0;
      end
   endtask

   task automatic check_errors(input string tag);
      check({tag, "_addr_err"}, addr_err, 0);
      check({tag, "_data_err"}, data_err, 0);
      check({tag, "_lat_err"}, lat_err, 0);
      check({tag, "_res_err"}, res_err + overlap_err, 0);
      check({tag, "_res_cnt"}, res_rd, res_wr);
   endtask

   initial begin
      int st, b_rd, b_w, b_b, b_f, b_ce, b_fce, b_pend, b_done, n;
      logic [3:0] cls3 [3];
      cls3[0] = 4'd7;
      cls3[1] = 4'd2;
      cls3[2] = 4'd9;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {o_mem_rd, o_ce, o_rst_processEnd, o_res_valid, o_busy, o_done,
                         o_timeout}, 0);
      check("rst_data", {o_mem_addr, o_weight, o_bias_fc, o_fmap, o_res_class, o_res_idx}, 0);
      @(negedge clk);
      global_rst_n = 1'b1;

      // One image: strobe counts, first-word timing, data via scoreboard
      b_rd = rd_cnt; b_w = rd_w; b_b = rd_b; b_f = rd_f; b_ce = ce_cnt;
      b_fce = f_ce_cnt; b_pend = pend_cnt; b_done = done_cnt;
      start_batch(8'd1, st);
      @(negedge clk);
      check("t1_first_rd", {o_mem_rd, o_busy, o_mem_addr}, {1'b1, 1'b1, 16'd0});
      check("t1_ce_low_at_s1", o_ce, 0);
      @(negedge clk);
      check("t1_ce_rise_at_s2", o_ce, 1);
      @(negedge clk);
      check("t1_weight0_at_s3", o_weight, 8'h00);
      wait_fce("t1_fmap_ce", b_fce + NP);
      finish_img(4'd3, 1'b0, 8'd0);
      wait_done("t1_done", b_done + 1);
      check("t1_rd_w", rd_w - b_w, NW);
      check("t1_rd_b", rd_b - b_b, NB);
      check("t1_rd_f", rd_f - b_f, NP);
      check("t1_ce_cnt", ce_cnt - b_ce, NRD);
      check("t1_pend", pend_cnt - b_pend, 1);
      check_errors("t1");

      // Zero images
      b_rd = rd_cnt; b_ce = ce_cnt; b_done = done_cnt;
      start_batch(8'd0, st);
      repeat (4) @(negedge clk);
      #1;
      check("t2_done_cyc", last_done, st + 2);
      check("t2_done_cnt", done_cnt - b_done, 1);
      check("t2_no_rd_ce", {rd_cnt - b_rd, ce_cnt - b_ce}, 0);
      check("t2_idle", o_busy, 0);

      // Three images, classes 7, 2, 9
      b_rd = rd_cnt; b_fce = f_ce_cnt; b_pend = pend_cnt; b_done = done_cnt;
      start_batch(8'd3, st);
      for (int i = 0; i < 3; i++) begin
         wait_fce("t3_fmap_ce", b_fce + NP * (i + 1));
         finish_img(cls3[i], 1'b0, 8'(i));
      end
      wait_done("t3_done", b_done + 1);
      check("t3_img1_faddr", faddr[1], 4254);
      check("t3_img2_faddr", faddr[2], 5278);
      check("t3_rd_cnt", rd_cnt - b_rd, 3 * NRD);
      check("t3_pend", pend_cnt - b_pend, 3);
      check_errors("t3");

      // Timeout: no cls_end
      b_fce = f_ce_cnt; b_pend = pend_cnt; b_done = done_cnt;
      start_batch(8'd1, st);
      wait_fce("t4_fmap_ce", b_fce + NP);
      n = 0;
      while (!o_timeout && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      check("t4_timeout_set", o_timeout, 1);
      check("t4_timeout_cyc", tmo_rise, last_f_ce + 101);
      repeat (3) @(negedge clk);
      #1;
      check("t4_done_cnt", done_cnt - b_done, 1);
      check("t4_done_cyc", last_done, tmo_rise + 1);
      check("t4_no_pend", pend_cnt - b_pend, 0);
      check("t4_sticky", {o_timeout, o_busy}, 2'b10);
      start_batch(8'd0, st);
      @(negedge clk);
      check("t4_timeout_clr", o_timeout, 0);
      repeat (3) @(negedge clk);

      // Reset mid-pixel load, then rerun with same-cycle en/end and a stray start
      b_rd = rd_cnt; b_pend = pend_cnt;
      start_batch(8'd1, st);
      n = 0;
      while (rd_cnt < b_rd + NWB + 500 && n < 6000) begin
         @(negedge clk); #1;
         n++;
      end
      check("t5_reach_pix500", rd_cnt - b_rd, NWB + 500);
      #1;
      global_rst_n = 1'b0;
      #1;
      check("t5_abort_ctrl", {o_mem_rd, o_ce, o_rst_processEnd, o_res_valid, o_busy, o_done,
                              o_timeout}, 0);
      check("t5_abort_data", {o_mem_addr, o_weight, o_bias_fc, o_fmap, o_res_class,
                              o_res_idx}, 0);
      check("t5_abort_no_pend", pend_cnt - b_pend, 0);
      @(negedge clk);
      #2;
      global_rst_n = 1'b1;

      b_rd = rd_cnt; b_fce = f_ce_cnt; b_pend = pend_cnt; b_done = done_cnt;
      start_batch(8'd1, st);
      @(negedge clk);
      check("t6_rerun_addr0", {o_mem_rd, o_mem_addr}, {1'b1, 16'd0});
      repeat (4) @(posedge clk);
      #1;
      i_num_img = 8'd3;
      i_start   = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      wait_fce("t6_fmap_ce", b_fce + NP);
      finish_img(4'd5, 1'b1, 8'd0);
      wait_done("t6_done", b_done + 1);
      check("t6_pend", pend_cnt - b_pend, 1);
      check("t6_class5", o_res_class, 4'd5);
      repeat (20) @(negedge clk);
      #1;
      check("t6_start_ignored", rd_cnt - b_rd, NRD);
      check("t6_idle", {o_busy, done_cnt - b_done}, 1);
      check_errors("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete (observed timeout, expected finish)");
      $fatal(1, "watchdog");
   end

endmodule
